// File: rtl/memory_stage_module_if.sv
// memory_stage_module_if: execution-stage inputs, stall/flush controls and memory/writeback results
interface memory_stage_module_if;
  logic stall, flush;
  logic [31:0] add_result, alu_result, read_data2;
  logic [4:0] mux_out;
  logic zero, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [31:0] branch_target, wb_read_data, wb_alu_result;
  logic PCSrc;
  logic [4:0] wb_write_reg;
  logic wb_MemtoReg, wb_RegWrite;
  modport master (
    output stall, flush, add_result, alu_result, read_data2, mux_out, zero,
           MemtoReg, RegWrite, MemRead, MemWrite, Branch,
    input  branch_target, PCSrc, wb_read_data, wb_alu_result, wb_write_reg,
           wb_MemtoReg, wb_RegWrite
  );
  modport slave (
    input  stall, flush, add_result, alu_result, read_data2, mux_out, zero,
           MemtoReg, RegWrite, MemRead, MemWrite, Branch,
    output branch_target, PCSrc, wb_read_data, wb_alu_result, wb_write_reg,
           wb_MemtoReg, wb_RegWrite
  );
endinterface

// File: rtl/memory_stage_module.sv
// memory_stage_module: EX/MEM register, 64-word data memory and MEM/WB register
module memory_stage_module (
  input logic clk,
  input logic reset,
  memory_stage_module_if.slave bus
);
  typedef struct packed {
    logic [31:0] add_result, alu_result, read_data2;
    logic [4:0] write_reg;
    logic zero, mem_to_reg, reg_write, mem_read, mem_write, branch;
  } ex_mem_t;
  typedef struct packed {
    logic [31:0] read_data, alu_result;
    logic [4:0] write_reg;
    logic mem_to_reg, reg_write;
  } mem_wb_t;
  ex_mem_t ex, ex_in;
  mem_wb_t wb, wb_in;
  logic [31:0] mem [64];
  logic [31:0] rd;
  logic we, hold;
  assign ex_in = '{add_result: bus.add_result, alu_result: bus.alu_result,
                   read_data2: bus.read_data2, write_reg: bus.mux_out, zero: bus.zero,
                   mem_to_reg: bus.MemtoReg, reg_write: bus.RegWrite,
                   mem_read: bus.MemRead, mem_write: bus.MemWrite, branch: bus.Branch};
  assign hold = bus.stall && !bus.flush;
  // flush outranks stall, so a flushed store still commits its write
  assign we = ex.mem_write && !hold;
  assign rd = ex.mem_read ? mem[ex.alu_result[7:2]] : '0;
  assign wb_in = '{read_data: rd, alu_result: ex.alu_result, write_reg: ex.write_reg,
                   mem_to_reg: ex.mem_to_reg, reg_write: ex.reg_write};
  always_ff @(posedge clk) begin
    if (reset) begin
      ex <= ex_mem_t'(0);
      wb <= mem_wb_t'(0);
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      ex <= bus.flush ? ex_mem_t'(0) : bus.stall ? ex : ex_in;
      wb <= hold ? mem_wb_t'(0) : wb_in;
      if (we) mem[ex.alu_result[7:2]] <= ex.read_data2;
    end
  end
  assign bus.branch_target = ex.add_result;
  assign bus.PCSrc = ex.branch & ex.zero;
  assign bus.wb_read_data = wb.read_data;
  assign bus.wb_alu_result = wb.alu_result;
  assign bus.wb_write_reg = wb.write_reg;
  assign bus.wb_MemtoReg = wb.mem_to_reg;
  assign bus.wb_RegWrite = wb.reg_write;
endmodule

// File: tb/tb_memory_stage_module.sv
// tb_memory_stage_module: directed and random checks of the memory stage against an instruction-level model
module tb_memory_stage_module;
  logic clk = 0;
  logic reset = 0;
  memory_stage_module_if bus ();
  memory_stage_module dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    bit [31:0] tgt, addr, sdata;
    bit [4:0] rd;
    bit z, m2r, rw, mr, mw, br;
  } ins_t;
  ins_t m_ex;
  bit [31:0] m_mem [64];
  bit [31:0] w_data, w_alu;
  bit [4:0] w_reg;
  bit w_m2r, w_rw;
  int compared = 0;
  int mismatched = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(string tag);
    chk({tag, ".branch_target"}, bus.branch_target, m_ex.tgt);
    chk({tag, ".PCSrc"}, 32'(bus.PCSrc), 32'(m_ex.br & m_ex.z));
    chk({tag, ".wb_read_data"}, bus.wb_read_data, w_data);
    chk({tag, ".wb_alu_result"}, bus.wb_alu_result, w_alu);
    chk({tag, ".wb_write_reg"}, 32'(bus.wb_write_reg), 32'(w_reg));
    chk({tag, ".wb_MemtoReg"}, 32'(bus.wb_MemtoReg), 32'(w_m2r));
    chk({tag, ".wb_RegWrite"}, 32'(bus.wb_RegWrite), 32'(w_rw));
  endtask
  task automatic set_in(bit [31:0] tgt, bit [31:0] addr, bit [31:0] sdata, bit [4:0] rd,
                        bit z, bit m2r, bit rw, bit mr, bit mw, bit br, bit st, bit fl);
    bus.add_result = tgt; bus.alu_result = addr; bus.read_data2 = sdata; bus.mux_out = rd;
    bus.zero = z; bus.MemtoReg = m2r; bus.RegWrite = rw; bus.MemRead = mr;
    bus.MemWrite = mw; bus.Branch = br; bus.stall = st; bus.flush = fl;
  endtask
  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic store(bit [31:0] addr, bit [31:0] data);
    set_in(0, addr, data, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask
  task automatic load(bit [31:0] addr, bit [4:0] rd);
    set_in(0, addr, 0, rd, 0, 1, 1, 1, 0, 0, 0, 0);
  endtask
  // One clock edge: advance the instruction-level model, then compare every output
  task automatic step(string tag);
    ins_t cur;
    int word;
    bit [31:0] old;
    bit st, fl;
    @(posedge clk);
    cur = '{tgt: bus.add_result, addr: bus.alu_result, sdata: bus.read_data2, rd: bus.mux_out,
            z: bus.zero, m2r: bus.MemtoReg, rw: bus.RegWrite, mr: bus.MemRead,
            mw: bus.MemWrite, br: bus.Branch};
    st = bus.stall; fl = bus.flush;
    if (reset) begin
      m_ex = '0;
      {w_data, w_alu, w_reg, w_m2r, w_rw} = '0;
      foreach (m_mem[i]) m_mem[i] = 0;
    end else begin
      word = int'((m_ex.addr % 256) / 4);
      old = m_ex.mr ? m_mem[word] : 0;
      if (st && !fl) {w_data, w_alu, w_reg, w_m2r, w_rw} = '0;
      else {w_data, w_alu, w_reg, w_m2r, w_rw} = {old, m_ex.addr, m_ex.rd, m_ex.m2r, m_ex.rw};
      if (m_ex.mw && (!st || fl)) m_mem[word] = m_ex.sdata;
      if (fl) m_ex = '0;
      else if (!st) m_ex = cur;
    end
    #1;
    chk_all(tag);
  endtask
  initial begin
    bit [31:0] a;
    // reset overrides stall and flush; outputs zero during and after reset
    reset = 1;
    set_in(32'h1111, 32'h44, 32'h99, 5'd3, 1, 1, 1, 1, 1, 1, 1, 1);
    step("reset");
    chk("reset.target_zero", bus.branch_target, 0);
    reset = 0; idle();
    step("post_reset");
    chk("post_reset.data_zero", bus.wb_read_data, 0);
    // store then load
    store(32'h10, 32'hDEADBEEF); step("st10");
    load(32'h10, 5'd5); step("ld10");
    idle(); step("ld10_wb");
    chk("ld10.data", bus.wb_read_data, 32'hDEADBEEF);
    chk("ld10.m2r", 32'(bus.wb_MemtoReg), 1);
    // address wrap and ignored byte offset
    store(32'h104, 32'h12345678); step("st104");
    load(32'h04, 5'd6); step("ld04");
    load(32'h07, 5'd7); step("ld07");
    chk("wrap.ld04", bus.wb_read_data, 32'h12345678);
    idle(); step("ld07_wb");
    chk("wrap.ld07", bus.wb_read_data, 32'h12345678);
    // branch taken / not taken
    set_in(32'h40, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0); step("br_taken");
    chk("branch.pcsrc1", 32'(bus.PCSrc), 1);
    chk("branch.target", bus.branch_target, 32'h40);
    set_in(32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step("br_not");
    chk("branch.pcsrc0", 32'(bus.PCSrc), 0);
    // store held by a two-cycle stall
    store(32'h20, 32'hCAFEF00D); step("st20");
    load(32'h20, 5'd9); bus.stall = 1; step("stall1");
    chk("stall1.rw", 32'(bus.wb_RegWrite), 0);
    step("stall2");
    chk("stall2.rw", 32'(bus.wb_RegWrite), 0);
    bus.stall = 0; step("unstall");
    idle(); step("ld20_wb");
    chk("stall.data", bus.wb_read_data, 32'hCAFEF00D);
    // flush beats stall
    set_in(0, 32'h77, 0, 5'd7, 0, 0, 1, 0, 0, 0, 1, 1); step("flush_stall");
    idle(); step("flush_wb");
    chk("flush.rw", 32'(bus.wb_RegWrite), 0);
    // reset while a store sits in EX/MEM
    store(32'h30, 32'h55AA55AA); step("st30");
    reset = 1; bus.stall = 1; step("reset_mid");
    chk("reset_mid.pcsrc", 32'(bus.PCSrc), 0);
    reset = 0; load(32'h30, 5'd2); step("ld30");
    load(32'h10, 5'd3); step("ld10b");
    chk("reset_mid.word30", bus.wb_read_data, 0);
    idle(); step("ld10b_wb");
    chk("reset_mid.word10", bus.wb_read_data, 0);
    // randomized traffic over a few words so reads hit recent writes
    for (int n = 0; n < 600; n++) begin
      a = $urandom;
      a[7:2] = 6'($urandom_range(0, 7));
      reset = ($urandom_range(0, 49) == 0);
      set_in($urandom, a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      step("rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
